// File: rtl/mvau_weight_loader_pkg.sv
// Shared types and elaboration-time helpers for the MVAU runtime weight loader.
// Not a module, so it has no latency or backpressure.
package mvau_weight_loader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    // Beats in one complete weight image: one memory word per PE per address.
    function automatic int img_len(input int depth, input int pe);
        return depth * pe;
    endfunction

    // PE index counter width; a single-PE build still needs a 1-bit counter.
    function automatic int pe_cnt_bw(input int pe);
        return (pe > 1) ? $clog2(pe) : 1;
    endfunction

endpackage

// File: rtl/mvau_weight_loader_if.sv
// Weight stream in (AXI-Stream) and the shared PE weight-memory write bus out.
// The loader owns the slave modport; the writes on this bus have no backpressure.
interface mvau_weight_loader_if #(
    parameter int DW = 2,
    parameter int PE = 2,
    parameter int AW = 4
);
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tlast;
    logic          s_axis_tready;
    logic [PE-1:0] wmem_wr_en;
    logic [AW-1:0] wmem_wr_addr;
    logic [DW-1:0] wmem_wr_data;

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast,
        output s_axis_tready, wmem_wr_en, wmem_wr_addr, wmem_wr_data
    );

    modport master (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast,
        input  s_axis_tready, wmem_wr_en, wmem_wr_addr, wmem_wr_data
    );
endinterface

// File: rtl/mvau_wl_counter.sv
// Wrapping 0..MAX-1 counter with terminal-count flag; increments on the edge after inc.
// No handshake of its own: clr wins over inc.
module mvau_wl_counter #(
    parameter int MAX = 2,
    parameter int W   = 1
) (
    input  logic         aclk,
    input  logic         areset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         tc
);
    localparam logic [W-1:0] LAST = W'(MAX - 1);

    assign tc = (cnt == LAST);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= tc ? '0 : cnt + 1'b1;
        end
    end
endmodule

// File: rtl/mvau_weight_loader.sv
// Streams a weight image into the per-PE weight memories, PE index fastest; write 1 cycle after handshake.
// tready is high for the whole LOAD state; the memories never push back.
module mvau_weight_loader
    import mvau_weight_loader_pkg::*;
#(
    parameter int SIMD         = 2,
    parameter int TW           = 1,
    parameter int PE           = 2,
    parameter int WMEM_DEPTH   = 4,
    parameter int WMEM_ADDR_BW = 4
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic                 load_start,
    mvau_weight_loader_if.slave  bus,
    output logic                 busy,
    output logic                 load_done,
    output logic                 load_err
);
    localparam int PE_BW = pe_cnt_bw(PE);

    state_t                  state;
    state_t                  state_nxt;
    logic                    hs;
    logic                    clr;
    logic                    last_beat;
    logic                    pe_tc;
    logic                    addr_tc;
    logic [PE_BW-1:0]        pe_cnt;
    logic [WMEM_ADDR_BW-1:0] addr_cnt;
    logic [PE-1:0]           pe_onehot;

    assign hs        = bus.s_axis_tvalid & bus.s_axis_tready;
    assign last_beat = pe_tc & addr_tc;

    mvau_wl_counter #(.MAX(PE), .W(PE_BW)) u_pe_ctr (
        .aclk   (aclk),
        .areset (areset),
        .clr    (clr),
        .inc    (hs),
        .cnt    (pe_cnt),
        .tc     (pe_tc)
    );

    // Address advances only when the PE index wraps back to 0.
    mvau_wl_counter #(.MAX(WMEM_DEPTH), .W(WMEM_ADDR_BW)) u_addr_ctr (
        .aclk   (aclk),
        .areset (areset),
        .clr    (clr),
        .inc    (hs & pe_tc),
        .cnt    (addr_cnt),
        .tc     (addr_tc)
    );

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt         = state;
        bus.s_axis_tready = 1'b0;
        busy              = 1'b0;
        load_done         = 1'b0;
        clr               = 1'b0;
        case (state)
            IDLE: begin
                if (load_start) begin
                    clr       = 1'b1;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                bus.s_axis_tready = 1'b1;
                busy              = 1'b1;
                if (hs && (last_beat || bus.s_axis_tlast)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                load_done = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pe_onehot = '0;
        for (int p = 0; p < PE; p++) begin
            pe_onehot[p] = (pe_cnt == PE_BW'(p));
        end
    end

    // tlast must coincide exactly with the final beat; either mismatch is a length error.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            load_err <= 1'b0;
        end else if (clr) begin
            load_err <= 1'b0;
        end else if (hs && (last_beat != bus.s_axis_tlast)) begin
            load_err <= 1'b1;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            bus.wmem_wr_en   <= '0;
            bus.wmem_wr_addr <= '0;
            bus.wmem_wr_data <= '0;
        end else begin
            bus.wmem_wr_en <= hs ? pe_onehot : '0;
            if (hs) begin
                bus.wmem_wr_addr <= addr_cnt;
                bus.wmem_wr_data <= bus.s_axis_tdata;
            end
        end
    end
endmodule

// File: tb/tb_mvau_weight_loader.sv
// Directed bench for mvau_weight_loader at PE=2, WMEM_DEPTH=4 with an 8-bit word so beat values are visible.
module tb_mvau_weight_loader;
    localparam int SIMD  = 2;
    localparam int TW    = 4;
    localparam int PE    = 2;
    localparam int DEPTH = 4;
    localparam int AW    = 4;
    localparam int DW    = SIMD * TW;

    logic aclk       = 1'b0;
    logic areset     = 1'b1;
    logic load_start = 1'b0;
    logic busy;
    logic load_done;
    logic load_err;

    int n_tests = 0;
    int n_fail  = 0;

    mvau_weight_loader_if #(.DW(DW), .PE(PE), .AW(AW)) bus ();

    mvau_weight_loader #(
        .SIMD         (SIMD),
        .TW           (TW),
        .PE           (PE),
        .WMEM_DEPTH   (DEPTH),
        .WMEM_ADDR_BW (AW)
    ) dut (
        .aclk       (aclk),
        .areset     (areset),
        .load_start (load_start),
        .bus        (bus),
        .busy       (busy),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    always #5 aclk = ~aclk;

    // Advance to just after the next rising edge; outputs are stable and inputs may change.
    task automatic cyc();
        @(posedge aclk);
        #1;
    endtask

    task automatic test_reset();
        areset            = 1'b1;
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
        bus.s_axis_tdata  = '0;
        cyc();
        cyc();
        n_tests++;
        if (bus.s_axis_tready !== 1'b0 || busy !== 1'b0 || load_done !== 1'b0 || load_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: tready=%b busy=%b done=%b err=%b, expected all 0",
                     bus.s_axis_tready, busy, load_done, load_err);
        end
        n_tests++;
        if (bus.wmem_wr_en !== 2'b00 || bus.wmem_wr_addr !== 4'd0 || bus.wmem_wr_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_wr: en=%b addr=%0d data=%h, expected 00/0/00",
                     bus.wmem_wr_en, bus.wmem_wr_addr, bus.wmem_wr_data);
        end
        areset = 1'b0;
        cyc();
    endtask

    task automatic test_idle_tvalid();
        bus.s_axis_tvalid = 1'b1;
        bus.s_axis_tdata  = 8'h55;
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_tests++;
            if (bus.s_axis_tready !== 1'b0 || bus.wmem_wr_en !== 2'b00 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_tvalid[%0d]: tready=%b en=%b busy=%b, expected 0/00/0",
                         i, bus.s_axis_tready, bus.wmem_wr_en, busy);
            end
        end
        bus.s_axis_tvalid = 1'b0;
    endtask

    task automatic test_full_load(input string tag, input logic [7:0] base);
        logic [1:0] exp_en;
        load_start = 1'b1;
        cyc();
        load_start = 1'b0;
        n_tests++;
        if (bus.s_axis_tready !== 1'b1 || busy !== 1'b1 || load_err !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_start: tready=%b busy=%b err=%b, expected 1/1/0",
                     tag, bus.s_axis_tready, busy, load_err);
        end
        for (int k = 0; k < 8; k++) begin
            bus.s_axis_tdata  = base + 8'(k);
            bus.s_axis_tvalid = 1'b1;
            bus.s_axis_tlast  = (k == 7);
            cyc();
            exp_en = (k % 2 == 0) ? 2'b01 : 2'b10;
            n_tests++;
            if (bus.wmem_wr_en !== exp_en || bus.wmem_wr_addr !== 4'(k / 2) || bus.wmem_wr_data !== base + 8'(k)) begin
                n_fail++;
                $display("FAIL %s_write[%0d]: en=%b addr=%0d data=%h, expected en=%b addr=%0d data=%h",
                         tag, k, bus.wmem_wr_en, bus.wmem_wr_addr, bus.wmem_wr_data,
                         exp_en, k / 2, base + 8'(k));
            end
            n_tests++;
            if (load_done !== (k == 7) || bus.s_axis_tready !== (k != 7)) begin
                n_fail++;
                $display("FAIL %s_done[%0d]: done=%b tready=%b, expected done=%b tready=%b",
                         tag, k, load_done, bus.s_axis_tready, k == 7, k != 7);
            end
        end
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
        cyc();
        n_tests++;
        if (bus.wmem_wr_en !== 2'b00 || load_done !== 1'b0 || busy !== 1'b0 || load_err !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_end: en=%b done=%b busy=%b err=%b, expected 00/0/0/0",
                     tag, bus.wmem_wr_en, load_done, busy, load_err);
        end
    endtask

    task automatic test_gaps();
        logic [1:0] exp_en;
        load_start = 1'b1;
        cyc();
        load_start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            bus.s_axis_tdata  = 8'h40 + 8'(k);
            bus.s_axis_tvalid = 1'b1;
            bus.s_axis_tlast  = (k == 7);
            cyc();
            exp_en = (k % 2 == 0) ? 2'b01 : 2'b10;
            n_tests++;
            if (bus.wmem_wr_en !== exp_en || bus.wmem_wr_addr !== 4'(k / 2) ||
                bus.wmem_wr_data !== 8'h40 + 8'(k) || load_done !== (k == 7)) begin
                n_fail++;
                $display("FAIL gaps_write[%0d]: en=%b addr=%0d data=%h done=%b, expected en=%b addr=%0d data=%h done=%b",
                         k, bus.wmem_wr_en, bus.wmem_wr_addr, bus.wmem_wr_data, load_done,
                         exp_en, k / 2, 8'h40 + 8'(k), k == 7);
            end
            if (k < 7) begin
                bus.s_axis_tvalid = 1'b0;
                bus.s_axis_tlast  = 1'b0;
                bus.s_axis_tdata  = 8'hAA;
                cyc();
                n_tests++;
                if (bus.wmem_wr_en !== 2'b00 || bus.wmem_wr_addr !== 4'(k / 2) || bus.wmem_wr_data !== 8'h40 + 8'(k)) begin
                    n_fail++;
                    $display("FAIL gaps_hold[%0d]: en=%b addr=%0d data=%h, expected en=00 addr=%0d data=%h",
                             k, bus.wmem_wr_en, bus.wmem_wr_addr, bus.wmem_wr_data, k / 2, 8'h40 + 8'(k));
                end
            end
        end
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
        cyc();
        n_tests++;
        if (busy !== 1'b0 || load_err !== 1'b0 || bus.wmem_wr_en !== 2'b00) begin
            n_fail++;
            $display("FAIL gaps_end: busy=%b err=%b en=%b, expected 0/0/00", busy, load_err, bus.wmem_wr_en);
        end
    endtask

    task automatic test_early_tlast();
        logic [1:0] exp_en;
        load_start = 1'b1;
        cyc();
        load_start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            bus.s_axis_tdata  = 8'h60 + 8'(k);
            bus.s_axis_tvalid = 1'b1;
            bus.s_axis_tlast  = (k == 4);
            cyc();
            exp_en = (k % 2 == 0) ? 2'b01 : 2'b10;
            n_tests++;
            if (bus.wmem_wr_en !== exp_en || bus.wmem_wr_addr !== 4'(k / 2) ||
                bus.wmem_wr_data !== 8'h60 + 8'(k) || load_done !== (k == 4)) begin
                n_fail++;
                $display("FAIL early_write[%0d]: en=%b addr=%0d data=%h done=%b, expected en=%b addr=%0d data=%h done=%b",
                         k, bus.wmem_wr_en, bus.wmem_wr_addr, bus.wmem_wr_data, load_done,
                         exp_en, k / 2, 8'h60 + 8'(k), k == 4);
            end
        end
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
        n_tests++;
        if (load_err !== 1'b1 || bus.s_axis_tready !== 1'b0) begin
            n_fail++;
            $display("FAIL early_err: err=%b tready=%b, expected 1/0", load_err, bus.s_axis_tready);
        end
        cyc();
        n_tests++;
        if (load_err !== 1'b1 || busy !== 1'b0 || bus.wmem_wr_en !== 2'b00 || load_done !== 1'b0) begin
            n_fail++;
            $display("FAIL early_sticky: err=%b busy=%b en=%b done=%b, expected 1/0/00/0",
                     load_err, busy, bus.wmem_wr_en, load_done);
        end
    endtask

    task automatic test_no_tlast();
        logic [1:0] exp_en;
        load_start = 1'b1;
        cyc();
        load_start = 1'b0;
        n_tests++;
        if (load_err !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL err_clear: err=%b busy=%b, expected 0/1", load_err, busy);
        end
        for (int k = 0; k < 8; k++) begin
            bus.s_axis_tdata  = 8'h10 + 8'(k);
            bus.s_axis_tvalid = 1'b1;
            bus.s_axis_tlast  = 1'b0;
            cyc();
            exp_en = (k % 2 == 0) ? 2'b01 : 2'b10;
            n_tests++;
            if (bus.wmem_wr_en !== exp_en || bus.wmem_wr_addr !== 4'(k / 2) ||
                bus.wmem_wr_data !== 8'h10 + 8'(k) || load_done !== (k == 7)) begin
                n_fail++;
                $display("FAIL notlast_write[%0d]: en=%b addr=%0d data=%h done=%b, expected en=%b addr=%0d data=%h done=%b",
                         k, bus.wmem_wr_en, bus.wmem_wr_addr, bus.wmem_wr_data, load_done,
                         exp_en, k / 2, 8'h10 + 8'(k), k == 7);
            end
        end
        n_tests++;
        if (load_err !== 1'b1) begin
            n_fail++;
            $display("FAIL notlast_err: err=%b, expected 1", load_err);
        end
        // A ninth beat stays offered while the loader returns to IDLE.
        bus.s_axis_tdata = 8'h18;
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if (bus.s_axis_tready !== 1'b0) begin
                n_fail++;
                $display("FAIL ninth_tready[%0d]: tready=%b, expected 0", i, bus.s_axis_tready);
            end
            cyc();
            n_tests++;
            if (bus.wmem_wr_en !== 2'b00 || load_err !== 1'b1) begin
                n_fail++;
                $display("FAIL ninth_write[%0d]: en=%b err=%b, expected 00/1", i, bus.wmem_wr_en, load_err);
            end
        end
        bus.s_axis_tvalid = 1'b0;
    endtask

    task automatic test_reset_mid_load();
        load_start = 1'b1;
        cyc();
        load_start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.s_axis_tdata  = 8'h20 + 8'(k);
            bus.s_axis_tvalid = 1'b1;
            bus.s_axis_tlast  = 1'b0;
            cyc();
        end
        n_tests++;
        if (bus.wmem_wr_en !== 2'b01 || bus.wmem_wr_addr !== 4'd1 || bus.wmem_wr_data !== 8'h22) begin
            n_fail++;
            $display("FAIL rstmid_pre: en=%b addr=%0d data=%h, expected 01/1/22",
                     bus.wmem_wr_en, bus.wmem_wr_addr, bus.wmem_wr_data);
        end
        #2;
        areset = 1'b1;
        #1;
        n_tests++;
        if (bus.s_axis_tready !== 1'b0 || busy !== 1'b0 || load_done !== 1'b0 || load_err !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_ctrl: tready=%b busy=%b done=%b err=%b, expected all 0",
                     bus.s_axis_tready, busy, load_done, load_err);
        end
        n_tests++;
        if (bus.wmem_wr_en !== 2'b00 || bus.wmem_wr_addr !== 4'd0 || bus.wmem_wr_data !== 8'h00) begin
            n_fail++;
            $display("FAIL rstmid_wr: en=%b addr=%0d data=%h, expected 00/0/00",
                     bus.wmem_wr_en, bus.wmem_wr_addr, bus.wmem_wr_data);
        end
        bus.s_axis_tvalid = 1'b0;
        #2;
        areset = 1'b0;
        cyc();
        n_tests++;
        if (busy !== 1'b0 || bus.s_axis_tready !== 1'b0 || load_done !== 1'b0 || load_err !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_idle: busy=%b tready=%b done=%b err=%b, expected all 0",
                     busy, bus.s_axis_tready, load_done, load_err);
        end
        test_full_load("after_rst", 8'h30);
    endtask

    task automatic test_start_during_load();
        logic [1:0] exp_en;
        load_start = 1'b1;
        cyc();
        load_start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            bus.s_axis_tdata  = 8'h70 + 8'(k);
            bus.s_axis_tvalid = 1'b1;
            bus.s_axis_tlast  = (k == 7);
            load_start        = (k == 2 || k == 5);
            cyc();
            exp_en = (k % 2 == 0) ? 2'b01 : 2'b10;
            n_tests++;
            if (bus.wmem_wr_en !== exp_en || bus.wmem_wr_addr !== 4'(k / 2) ||
                bus.wmem_wr_data !== 8'h70 + 8'(k) || load_done !== (k == 7)) begin
                n_fail++;
                $display("FAIL restart_write[%0d]: en=%b addr=%0d data=%h done=%b, expected en=%b addr=%0d data=%h done=%b",
                         k, bus.wmem_wr_en, bus.wmem_wr_addr, bus.wmem_wr_data, load_done,
                         exp_en, k / 2, 8'h70 + 8'(k), k == 7);
            end
        end
        load_start        = 1'b0;
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
        n_tests++;
        if (load_err !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_err: err=%b, expected 0", load_err);
        end
        cyc();
        n_tests++;
        if (busy !== 1'b0 || bus.s_axis_tready !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_idle: busy=%b tready=%b, expected 0/0", busy, bus.s_axis_tready);
        end
    endtask

    initial begin
        bus.s_axis_tdata  = '0;
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
        test_reset();
        test_idle_tvalid();
        test_full_load("full", 8'h00);
        test_gaps();
        test_early_tlast();
        test_no_tlast();
        test_reset_mid_load();
        test_start_during_load();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
